// File: rtl/mandel_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mandel_scan_ctrl
//
// Frame-level initiator for a single pixel iteration engine. For each pixel of
// an H_RES x V_RES frame it issues (x, y) with a one-cycle gen_start pulse and
// waits for gen_ready. It then captures the iteration count and hands it,
// together with the linear pixel address, to the framebuffer writer over a
// valid/ready handshake.
//
// Optional feature macro: SCAN_ABORT_EN
//   When defined, the frame_abort input is present. frame_abort=1 in any
//   non-idle state returns the controller to IDLE and clears the scan
//   position. No frame_done pulse is produced in that case.
//
// Ports:
//   CLK            sole clock, rising edge
//   RST_N          asynchronous active-low reset
//   frame_start    one-cycle frame request, honoured only in IDLE
//   frame_abort    (SCAN_ABORT_EN only) abandon the current frame
//   frame_busy     high in every state except IDLE
//   frame_done     one-cycle pulse after the last pixel is accepted
//   gen_start      one-cycle start pulse to the engine
//   gen_x, gen_y   pixel coordinates, stable between gen_start pulses
//   gen_ready      engine result ready (combinational in the engine)
//   gen_iteration  engine iteration count, valid while gen_ready=1
//   pix_valid      output pixel valid
//   pix_ready      framebuffer writer accepts
//   pix_addr       linear address y*H_RES + x of the output pixel
//   pix_iter       captured iteration count
// -----------------------------------------------------------------------------
module mandel_scan_ctrl #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ITER_W = 65,
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              frame_start,
`ifdef SCAN_ABORT_EN
    input  logic              frame_abort,
`endif
    output logic              frame_busy,
    output logic              frame_done,
    output logic              gen_start,
    output logic [11:0]       gen_x,
    output logic [11:0]       gen_y,
    input  logic              gen_ready,
    input  logic [ITER_W-1:0] gen_iteration,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ITER_W-1:0] pix_iter
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    localparam logic [11:0]       X_LAST   = 12'(H_RES - 1);
    localparam logic [11:0]       Y_LAST   = 12'(V_RES - 1);
    localparam logic [11:0]       XY_ONE   = 12'd1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_r;
    state_t              state_s;
    logic [11:0]         x_r;
    logic [11:0]         y_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   pix_addr_r;
    logic [ITER_W-1:0]   pix_iter_r;
    logic                frame_done_r;

    logic                last_pix_s;
    logic                start_s;
    logic                capture_s;
    logic                advance_s;
    logic                finish_s;
    logic                abort_s;

    // Last pixel of the frame: bottom-right corner.
    always_comb begin
        last_pix_s = (x_r == X_LAST) && (y_r == Y_LAST);
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        capture_s = 1'b0;
        advance_s = 1'b0;
        finish_s  = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A request landing in the frame_done cycle is dropped so a
                // back-to-back restart always needs a fresh pulse in IDLE.
                if (frame_start && !frame_done_r) begin
                    state_s = ST_ISSUE;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // gen_ready is ignored here: it may still be high from the
                // previous pixel.
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (gen_ready) begin
                    state_s   = ST_OUT;
                    capture_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (pix_ready) begin
                    if (last_pix_s) begin
                        state_s  = ST_IDLE;
                        finish_s = 1'b1;
                    end else begin
                        state_s   = ST_ISSUE;
                        advance_s = 1'b1;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
`ifdef SCAN_ABORT_EN
        // Abort overrides any transition, including an acceptance.
        if (frame_abort && (state_r != ST_IDLE)) begin
            state_s   = ST_IDLE;
            start_s   = 1'b0;
            capture_s = 1'b0;
            advance_s = 1'b0;
            finish_s  = 1'b0;
            abort_s   = 1'b1;
        end else begin
            abort_s = 1'b0;
        end
`endif
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Scan position and linear address counter (no multiplier: addr simply
    // follows x/y in raster order).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_r    <= 12'd0;
            y_r    <= 12'd0;
            addr_r <= '0;
        end else if (start_s || abort_s) begin
            x_r    <= 12'd0;
            y_r    <= 12'd0;
            addr_r <= '0;
        end else if (advance_s) begin
            addr_r <= addr_r + ADDR_ONE;
            if (x_r == X_LAST) begin
                x_r <= 12'd0;
                y_r <= y_r + XY_ONE;
            end else begin
                x_r <= x_r + XY_ONE;
            end
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            addr_r <= addr_r;
        end
    end

    // Output pixel capture; held through backpressure until the next capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_addr_r <= '0;
            pix_iter_r <= '0;
        end else if (capture_s) begin
            pix_addr_r <= addr_r;
            pix_iter_r <= gen_iteration;
        end else begin
            pix_addr_r <= pix_addr_r;
            pix_iter_r <= pix_iter_r;
        end
    end

    // Frame completion pulse, high for the first IDLE cycle after the last pixel.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= finish_s;
        end
    end

    assign frame_busy = (state_r != ST_IDLE);
    assign gen_start  = (state_r == ST_ISSUE);
    assign pix_valid  = (state_r == ST_OUT);
    assign frame_done = frame_done_r;
    assign gen_x      = x_r;
    assign gen_y      = y_r;
    assign pix_addr   = pix_addr_r;
    assign pix_iter   = pix_iter_r;

endmodule
